// File: rtl/coprocessor_mem_pkg.sv
// Shared constants and the master-id type for the coprocessor main-memory arbiter.
package coprocessor_mem_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8704;

    typedef enum logic {
        MASTER_0 = 1'b0,
        MASTER_1 = 1'b1
    } master_id_t;

endpackage

// File: rtl/coprocessor_mem_rr_arb.sv
// Two-way round-robin grant; last_grant advances only when the granted request is accepted.
module coprocessor_mem_rr_arb
    import coprocessor_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    master_id_t last_grant_q;
    master_id_t last_grant_d;

    // Under contention the master that did not win last time is preferred.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant_q == MASTER_1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant[1] ? MASTER_1 : MASTER_0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= MASTER_1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/coprocessor_mem_arbiter.sv
// Shares the single-port main memory between the Nios host (m0) and the coprocessor core (m1).
// Optional MEM_ARB_BOUNDS_CHECK_EN blocks accesses at or above DEPTH and raises sticky err_oob.
module coprocessor_mem_arbiter
    import coprocessor_mem_pkg::*;
#(
    parameter int ADDR_W = coprocessor_mem_pkg::ADDR_W,
    parameter int DATA_W = coprocessor_mem_pkg::DATA_W,
    parameter int DEPTH  = coprocessor_mem_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    output logic                err_oob
);

    localparam int BE_W = DATA_W / 8;

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              granted;
    logic              accept;
    master_id_t        sel;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   sel_be;
    logic [DATA_W-1:0] sel_wdata;
    logic              oob;
    logic [DATA_W-1:0] ret_data;

    logic              rd_vld_q, rd_vld_d;
    master_id_t        rd_id_q, rd_id_d;
    logic              rd_oob_q, rd_oob_d;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign granted = |grant;
    assign accept  = granted & ~reset;

    coprocessor_mem_rr_arb u_rr_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // A write strobe dominates: a simultaneous read strobe is dropped.
    always_comb begin
        sel       = grant[1] ? MASTER_1 : MASTER_0;
        sel_write = m0_write;
        sel_addr  = m0_address;
        sel_be    = m0_byteenable;
        sel_wdata = m0_writedata;
        if (sel == MASTER_1) begin
            sel_write = m1_write;
            sel_addr  = m1_address;
            sel_be    = m1_byteenable;
            sel_wdata = m1_writedata;
        end
        oob = BOUNDS_EN & (32'(sel_addr) >= 32'(DEPTH));
    end

    assign mem_address    = sel_addr;
    assign mem_byteenable = sel_write ? sel_be : {BE_W{1'b1}};
    assign mem_writedata  = sel_wdata;
    assign mem_chipselect = granted & ~reset & ~oob;
    assign mem_write      = granted & sel_write & ~reset & ~oob;
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = reset | (req[0] & ~grant[0]);
    assign m1_waitrequest = reset | (req[1] & ~grant[1]);

    always_comb begin
        rd_vld_d = accept & ~sel_write;
        rd_id_d  = sel;
        rd_oob_d = oob;
    end

    // Read-return stage: only the valid bit is reset; id/oob are qualified by it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= rd_vld_d;
        end
        rd_id_q  <= rd_id_d;
        rd_oob_q <= rd_oob_d;
    end

    assign ret_data         = rd_oob_q ? '0 : mem_readdata;
    assign m0_readdata      = ret_data;
    assign m1_readdata      = ret_data;
    assign m0_readdatavalid = rd_vld_q & ~reset & (rd_id_q == MASTER_0);
    assign m1_readdatavalid = rd_vld_q & ~reset & (rd_id_q == MASTER_1);

`ifdef MEM_ARB_BOUNDS_CHECK_EN
    logic err_oob_q, err_oob_d;

    always_comb begin
        err_oob_d = err_oob_q | (accept & oob);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_oob_q <= 1'b0;
        end else begin
            err_oob_q <= err_oob_d;
        end
    end

    assign err_oob = err_oob_q;
`else
    assign err_oob = 1'b0;
`endif

endmodule

// File: tb/tb_coprocessor_mem_arbiter.sv
// Self-checking bench for coprocessor_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (round-robin winner, expected memory image, pending read).
module tb_coprocessor_mem_arbiter;

    localparam int DEPTH = 8704;
`ifdef MEM_ARB_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        err_oob;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coprocessor_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .err_oob          (err_oob)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Behavioural single-port RAM with registered read output.
    logic [31:0] ram [0:16383];
    logic [31:0] ram_rdq;
    assign mem_readdata = ram_rdq;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
            else           ram_rdq <= ram[mem_address];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:16383];
    int          last_win = 1;
    bit          pend_vld = 1'b0;
    int          pend_id  = 0;
    logic [31:0] pend_data;
    bit          exp_err  = 1'b0;
    bit          hold0 = 1'b0, hold1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int n, input logic rd, input logic wr, input logic [13:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (n == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    task automatic idle_all();
        set_m(0, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 14'h0, 4'h0, 32'h0);
    endtask

    // One clock cycle: check the DUT against the model at the falling edge, advance the model,
    // then return just after the next rising edge.
    task automatic step();
        bit          r0, r1, wr, oob;
        int          win;
        logic [13:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        @(negedge clk);
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        check("rdv0", m0_readdatavalid, !reset && pend_vld && pend_id == 0);
        check("rdv1", m1_readdatavalid, !reset && pend_vld && pend_id == 1);
        if (!reset && pend_vld) begin
            if (pend_id == 0) check("rdata0", m0_readdata, pend_data);
            else              check("rdata1", m1_readdata, pend_data);
        end
        check("err_oob", err_oob, exp_err);
        pend_vld = 1'b0;
        hold0 = 1'b0;
        hold1 = 1'b0;
        if (reset) begin
            check("rst_wait0", m0_waitrequest, 1);
            check("rst_wait1", m1_waitrequest, 1);
            check("rst_cs", mem_chipselect, 0);
            last_win = 1;
            exp_err  = 1'b0;
        end else begin
            win = -1;
            if (r0 && r1)  win = (last_win == 0) ? 1 : 0;
            else if (r0)   win = 0;
            else if (r1)   win = 1;
            check("wait0", m0_waitrequest, r0 && win != 0);
            check("wait1", m1_waitrequest, r1 && win != 1);
            hold0 = r0 && win != 0;
            hold1 = r1 && win != 1;
            if (win < 0) begin
                check("idle_cs", mem_chipselect, 0);
            end else begin
                wr  = (win == 0) ? m0_write : m1_write;
                a   = (win == 0) ? m0_address : m1_address;
                be  = (win == 0) ? m0_byteenable : m1_byteenable;
                wd  = (win == 0) ? m0_writedata : m1_writedata;
                oob = BCHK && (int'(a) >= DEPTH);
                check("mem_cs", mem_chipselect, !oob);
                if (!oob) begin
                    check("mem_addr", mem_address, a);
                    check("mem_wr", mem_write, wr);
                    check("mem_be", mem_byteenable, wr ? be : 4'hF);
                    if (wr) check("mem_wdata", mem_writedata, wd);
                end
                last_win = win;
                if (oob) exp_err = 1'b1;
                if (wr) begin
                    if (!oob) ref_mem[a] = merge(ref_mem[a], wd, be);
                end else begin
                    pend_vld  = 1'b1;
                    pend_id   = win;
                    pend_data = oob ? 32'h0 : ref_mem[a];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_master(input int n);
        int          kind;
        logic [13:0] a;
        kind = $urandom_range(0, 7);
        a    = 14'($urandom_range(0, 15));
        if (BCHK && $urandom_range(0, 9) == 0) a = 14'(DEPTH + $urandom_range(0, 5));
        set_m(n, kind inside {1, 2, 3, 7}, kind inside {4, 5, 7}, a,
              4'($urandom_range(0, 15)), $urandom);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram_rdq = 32'h0;
        reset   = 1'b1;
        idle_all();
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b0;

        // Write then read back on m0; m1 stays idle.
        set_m(0, 1'b0, 1'b1, 14'h0010, 4'hF, 32'hDEADBEEF);
        step();
        set_m(0, 1'b1, 1'b0, 14'h0010, 4'h0, 32'h0);
        step();
        idle_all();
        check("t1_rdv0", m0_readdatavalid, 1);
        check("t1_rdata0", m0_readdata, 32'hDEADBEEF);
        check("t1_rdv1", m1_readdatavalid, 0);
        step();

        // Preload distinct words, then contention right after reset: m0 first, then alternate.
        set_m(0, 1'b0, 1'b1, 14'h0001, 4'hF, 32'h11111111);
        set_m(1, 1'b0, 1'b1, 14'h0002, 4'hF, 32'h22222222);
        step();
        step();
        idle_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 14'h0001, 4'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 14'h0002, 4'h0, 32'h0);
        #1;
        check("t2_first_wait", {m1_waitrequest, m0_waitrequest}, 2'b10);
        repeat (6) step();
        idle_all();
        step();

        // Partial byte-enable write over a full word.
        set_m(1, 1'b0, 1'b1, 14'h0020, 4'hF, 32'hAAAAAAAA);
        step();
        set_m(1, 1'b0, 1'b1, 14'h0020, 4'h3, 32'h12345678);
        step();
        set_m(1, 1'b1, 1'b0, 14'h0020, 4'h0, 32'h0);
        step();
        idle_all();
        check("t3_rdv1", m1_readdatavalid, 1);
        check("t3_merge", m1_readdata, 32'hAAAA5678);
        step();

        // Reset in the cycle after an accepted read suppresses the return.
        set_m(0, 1'b1, 1'b0, 14'h0010, 4'h0, 32'h0);
        step();
        idle_all();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_m(0, 1'b1, 1'b0, 14'h0001, 4'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 14'h0002, 4'h0, 32'h0);
        #1;
        check("t4_first_wait", {m1_waitrequest, m0_waitrequest}, 2'b10);
        repeat (2) step();
        idle_all();
        step();

`ifdef MEM_ARB_BOUNDS_CHECK_EN
        // Out-of-range accesses: blocked from memory, read returns zero, sticky error.
        set_m(1, 1'b0, 1'b1, 14'd8704, 4'hF, 32'h55555555);
        #1;
        check("t5_cs_wr", mem_chipselect, 0);
        step();
        set_m(1, 1'b1, 1'b0, 14'd8704, 4'h0, 32'h0);
        step();
        idle_all();
        check("t5_rdv1", m1_readdatavalid, 1);
        check("t5_rdata1", m1_readdata, 32'h0);
        check("t5_err_set", err_oob, 1);
        step();
        step();
        check("t5_err_hold", err_oob, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5_err_clr", err_oob, 0);
`endif

        // Read and write strobes together act as a write.
        set_m(0, 1'b1, 1'b1, 14'h0100, 4'hF, 32'h0000CAFE);
        step();
        set_m(0, 1'b1, 1'b0, 14'h0100, 4'h0, 32'h0);
        check("t6_no_rdv", m0_readdatavalid, 0);
        step();
        idle_all();
        check("t6_rdv0", m0_readdatavalid, 1);
        check("t6_rdata0", m0_readdata, 32'h0000CAFE);
        step();

        // Randomized traffic; ungranted requests are held stable.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 79) == 0);
            if (!hold0) rand_master(0);
            if (!hold1) rand_master(1);
            step();
        end
        reset = 1'b0;
        idle_all();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
